aes_pt_unpacker: RTL and testbench
==================================

Name: aes_pt_unpacker

Overview:
- Sits directly downstream of the 192-bit AES decryption wrapper and consumes its plaintext output (`pt`, `pt_vld`).
- The decryptor's plaintext port has no backpressure, so this block does two things:
  - buffers whole 128-bit plaintext blocks;
  - issues a credit signal (`ct_allow`) that the system ANDs into the decryptor's `ct_vld`, so a block is only started when buffer space is guaranteed.
- Buffered blocks are serialised onto a 32-bit valid/ready word stream toward the host interface.

Parameters:
- DEPTH, 4, number of 128-bit plaintext blocks buffered; must be ≥ 1.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and in-flight counters; derived, never overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pt  in  128  plaintext from the decryptor; bit 0 is the MSB of the block.
- pt_vld  in  1  single-cycle strobe: `pt` is valid this cycle.
- ct_fire  in  1  the decryptor accepted a ciphertext this cycle (`ct_vld` & `ct_rdy` at the decryptor).
- ct_allow  out  1  high when one more ciphertext may be issued without risk of plaintext overflow.
- dout  out  32  plaintext word.
- dout_vld  out  1  `dout` is valid.
- dout_rdy  in  1  downstream accepts `dout`.
- dout_last  out  1  high with the 4th (final) word of a block.
- ovf  out  1  sticky: a plaintext arrived while the buffer was full; the block was dropped.
- unsol  out  1  sticky: `pt_vld` arrived with zero blocks in flight.

Behaviour:
- Reset (`rst` low, asynchronous):
  - `ct_allow`=1 (DEPTH ≥ 1); `dout`=0, `dout_vld`=0, `dout_last`=0, `ovf`=0, `unsol`=0.
  - Pointers, `occ` (buffered blocks), `inflight` and word index all cleared; buffer contents are don't-care.
- Reset mid-operation:
  - The partial block being read out and all buffered blocks are discarded.
  - `inflight` clears, so blocks that arrive afterwards set `unsol`. The system resets the decryptor with the same `rst`.
- Credit:
  - `ct_allow` = (`occ` + `inflight` < DEPTH), registered; it updates the cycle after any counter change.
  - `inflight`: +1 on `ct_fire`, −1 on `pt_vld`; unchanged when both occur in the same cycle.
  - `inflight` never wraps: decrement at 0 is suppressed and sets `unsol`; increment at DEPTH is suppressed.
- Write:
  - On `pt_vld` with `occ` < DEPTH, `pt` is stored at `wptr`; `wptr` advances modulo DEPTH.
  - On `pt_vld` with `occ` == DEPTH and no block finishing readout this cycle, the block is dropped, `ovf` is set, and it stays set until reset.
  - A write to a full buffer in the same cycle that the last word of the head block is accepted is legal; `occ` is unchanged.
- Read / serialise:
  - `dout_vld` = (`occ` > 0).
  - `dout` = word `widx` of the head block: `widx`=0 → `pt`[0:31], 1 → [32:63], 2 → [64:95], 3 → [96:127].
  - `widx` advances on `dout_vld` & `dout_rdy`.
  - At `widx`=3, `dout_last`=1; on acceptance `widx` wraps to 0, `rptr` advances and `occ` decrements.
  - `dout`/`dout_vld` hold stable while `dout_rdy`=0.
- Latency: `pt_vld` in cycle N into an empty buffer gives `dout_vld`=1 with word 0 in cycle N+1. With `dout_rdy` held high, a block drains in 4 cycles.
- Throughput: 1 word per clock; no bubble between consecutive blocks.
- Simultaneous write and final-word read: both take effect; `occ` is unchanged.
- DEPTH=1: write and read pointers are constant 0; behaviour is otherwise identical.

Decomposition:
- Shared package `aes_pkg` holds:
  - AES_BLK_W=128, AES_WORD_W=32, AES_WORDS_PER_BLK=4;
  - typedef `aes_blk_t` (logic [0:127]) and typedef `aes_word_t` (logic [31:0]).
- One sub-module, `aes_blk_fifo`: a DEPTH × 128 storage array with `wptr`/`rptr`/`occ`, full/empty and a same-cycle write-while-pop rule.
- Credit, word serialiser and sticky flags stay in `aes_pt_unpacker`.

Test Plan:
- Reset then idle → `ct_allow`=1, `dout_vld`=0, `ovf`=0, `unsol`=0. Assert `rst` low mid-readout → all outputs return to reset values asynchronously, without waiting for a clock edge.
- `ct_fire`×1, then `pt_vld` with `pt`=0x00112233_44556677_8899AABB_CCDDEEFF, `dout_rdy`=1:
  - `dout` = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF in cycles N+1..N+4;
  - `dout_last` high only in N+4.
- DEPTH=4, `dout_rdy`=0: `ct_fire`×4 → `ct_allow`=0 after the 4th; four `pt_vld` blocks are all stored, `ovf`=0; `ct_allow` stays 0 until the first block fully drains.
- Buffer full, then `pt_vld` with `dout_rdy`=0 → `ovf`=1 and sticky; the head block is still output intact.
- Buffer full, `pt_vld` in the same cycle the 4th word is accepted → no `ovf`, `occ` unchanged, the new block appears in order.
- `pt_vld` with `inflight`=0 → `unsol`=1 and the block is still buffered. `ct_fire` and `pt_vld` in the same cycle → `inflight` unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block/word widths and types
package aes_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_WORDS_PER_BLK = 4;
  typedef logic [0:AES_BLK_W-1] aes_blk_t;
  typedef logic [AES_WORD_W-1:0] aes_word_t;
endpackage

// File: rtl/aes_pt_unpacker_if.sv
// aes_pt_unpacker_if: plaintext in, credit out and word stream out of the unpacker
interface aes_pt_unpacker_if;
  import aes_pkg::*;
  aes_blk_t pt;
  logic pt_vld;
  logic ct_fire;
  logic ct_allow;
  aes_word_t dout;
  logic dout_vld;
  logic dout_rdy;
  logic dout_last;
  logic ovf;
  logic unsol;
  modport master (
    output pt, pt_vld, ct_fire, dout_rdy,
    input ct_allow, dout, dout_vld, dout_last, ovf, unsol
  );
  modport slave (
    input pt, pt_vld, ct_fire, dout_rdy,
    output ct_allow, dout, dout_vld, dout_last, ovf, unsol
  );
endinterface

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: DEPTH x 128-bit block buffer; a push while full is legal only with a same-cycle pop
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  aes_blk_t wdata,
  input  logic pop,
  output aes_blk_t rdata,
  output logic [CNT_W-1:0] occ,
  output logic full,
  output logic empty
);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  aes_blk_t mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  assign rdata = mem[rptr];
  assign full = occ == CNT_W'(DEPTH);
  assign empty = occ == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      occ <= '0;
    end else begin
      if (push) wptr <= wptr == LAST ? '0 : wptr + PW'(1);
      if (pop) rptr <= rptr == LAST ? '0 : rptr + PW'(1);
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
endmodule

// File: rtl/aes_pt_unpacker.sv
// aes_pt_unpacker: buffers decrypted blocks, issues ciphertext credit and serialises blocks into 32-bit words
module aes_pt_unpacker
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  aes_pt_unpacker_if.slave io
);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] occ, occ_nx, inflight, inflight_nx;
  logic [1:0] widx;
  logic full, empty, push, pop, acc;
  logic allow_q, ovf_q, unsol_q;
  aes_blk_t head;
  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk, .rst, .push, .wdata(io.pt), .pop, .rdata(head), .occ, .full, .empty
  );
  always_comb begin
    acc = ~empty & io.dout_rdy;
    pop = acc & (widx == 2'd3);
    push = io.pt_vld & (~full | pop);
    occ_nx = occ + CNT_W'(push) - CNT_W'(pop);
    inflight_nx = (io.ct_fire & ~io.pt_vld & inflight != DMAX) ? inflight + ONE :
                  (io.pt_vld & ~io.ct_fire & inflight != '0) ? inflight - ONE : inflight;
  end
  assign io.dout_vld = ~empty;
  assign io.dout_last = ~empty & (widx == 2'd3);
  assign io.dout = empty ? '0 : head[{widx, 5'd0} +: AES_WORD_W];
  assign io.ct_allow = allow_q;
  assign io.ovf = ovf_q;
  assign io.unsol = unsol_q;
  // credit looks at next-state counters so it drops in the cycle right after the last allowed fire
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      widx <= '0;
      inflight <= '0;
      allow_q <= 1'b1;
      ovf_q <= 1'b0;
      unsol_q <= 1'b0;
    end else begin
      widx <= widx + 2'(acc);
      inflight <= inflight_nx;
      allow_q <= ({1'b0, occ_nx} + {1'b0, inflight_nx}) < (CNT_W + 1)'(DEPTH);
      ovf_q <= ovf_q | (io.pt_vld & full & ~pop);
      unsol_q <= unsol_q | (io.pt_vld & inflight == '0);
    end
endmodule

// File: tb/tb_aes_pt_unpacker.sv
// tb_aes_pt_unpacker: table vectors, directed corner sequences and random traffic against a queue model
module tb_aes_pt_unpacker;
  import aes_pkg::*;
  localparam int D = 4;
  logic clk = 0;
  logic rst = 0;
  int total = 0;
  int bad = 0;
  aes_pt_unpacker_if io ();
  aes_pt_unpacker #(.DEPTH(D)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;

  aes_blk_t q[$];
  int m_widx, m_infl;
  bit m_ovf, m_unsol;

  typedef struct {
    bit pv; aes_blk_t p; bit cf; bit rdy;
    aes_word_t dout; bit vld; bit last; bit allow;
  } vec_t;
  vec_t tbl[6];

  function automatic aes_word_t word_of(aes_blk_t b, int w);
    logic [127:0] t;
    t = b;
    return aes_word_t'(t >> (96 - 32 * w));
  endfunction

  function automatic logic [127:0] exp_out();
    bit vld, last, allow;
    aes_word_t w;
    vld = q.size() > 0;
    last = vld && m_widx == 3;
    allow = (q.size() + m_infl) < D;
    w = vld ? word_of(q[0], m_widx) : 32'h0;
    return 128'({allow, vld, last, m_ovf, m_unsol, w});
  endfunction

  function automatic logic [127:0] act_out();
    return 128'({io.ct_allow, io.dout_vld, io.dout_last, io.ovf, io.unsol, io.dout});
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_widx = 0;
    m_infl = 0;
    m_ovf = 0;
    m_unsol = 0;
  endtask

  task automatic step(input bit pv, input aes_blk_t p, input bit cf, input bit rdy);
    int sz;
    bit vld, popb;
    io.pt_vld = pv; io.pt = p; io.ct_fire = cf; io.dout_rdy = rdy;
    sz = q.size();
    vld = sz > 0;
    popb = vld && rdy && m_widx == 3;
    if (vld && rdy) begin
      if (m_widx == 3) begin q.delete(0); m_widx = 0; end
      else m_widx++;
    end
    if (pv) begin
      if (m_infl == 0) m_unsol = 1;
      if (sz < D || popb) q.push_back(p);
      else m_ovf = 1;
    end
    if (cf && !pv && m_infl < D) m_infl++;
    else if (pv && !cf && m_infl > 0) m_infl--;
    @(posedge clk); #1;
    io.pt_vld = 0; io.ct_fire = 0;
    chk("outputs", act_out(), exp_out());
  endtask

  task automatic reset_dut();
    io.pt_vld = 0; io.pt = '0; io.ct_fire = 0; io.dout_rdy = 0;
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("reset_state", act_out(), exp_out());
  endtask

  function automatic aes_blk_t rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam aes_blk_t KNOWN = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    tbl[0] = '{0, '0, 1, 1, 32'h0, 0, 0, 1};
    tbl[1] = '{1, KNOWN, 0, 1, 32'h00112233, 1, 0, 1};
    tbl[2] = '{0, '0, 0, 1, 32'h44556677, 1, 0, 1};
    tbl[3] = '{0, '0, 0, 1, 32'h8899AABB, 1, 0, 1};
    tbl[4] = '{0, '0, 0, 1, 32'hCCDDEEFF, 1, 1, 1};
    tbl[5] = '{0, '0, 0, 1, 32'h0, 0, 0, 1};

    reset_dut();
    chk("reset_literal", act_out(), 128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].pv, tbl[i].p, tbl[i].cf, tbl[i].rdy);
      chk($sformatf("tbl%0d_dout", i), 128'(io.dout), 128'(tbl[i].dout));
      chk($sformatf("tbl%0d_flags", i), 128'({io.dout_vld, io.dout_last, io.ct_allow}),
          128'({tbl[i].vld, tbl[i].last, tbl[i].allow}));
    end

    // async reset mid-readout
    reset_dut();
    step(0, '0, 1, 1);
    step(1, KNOWN, 0, 1);
    step(0, '0, 0, 1);
    #2 rst = 0;
    #1 chk("async_rst", act_out(), 128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
    model_reset();
    @(posedge clk); #1 rst = 1;
    step(0, '0, 0, 1);

    // fill with credit, then overflow
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1, 0);
      if (i == 2) chk("allow_after3", 128'(io.ct_allow), 128'(1));
    end
    chk("allow_after4", 128'(io.ct_allow), 128'(0));
    for (int i = 0; i < 4; i++) step(1, rnd_blk(), 0, 0);
    chk("full_no_ovf", 128'(io.ovf), 128'(0));
    chk("full_allow", 128'(io.ct_allow), 128'(0));
    step(1, rnd_blk(), 0, 0);
    chk("ovf_set", 128'(io.ovf), 128'(1));
    chk("head_intact", 128'(io.dout), 128'(word_of(q[0], 0)));
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("ovf_sticky", 128'(io.ovf), 128'(1));
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
    chk("allow_held", 128'(io.ct_allow), 128'(0));
    step(0, '0, 0, 1);
    chk("allow_after_drain", 128'(io.ct_allow), 128'(1));
    repeat (14) step(0, '0, 0, 1);

    // write to full buffer while the head's last word is accepted
    reset_dut();
    repeat (4) step(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, rnd_blk(), 0, 0);
    repeat (3) step(0, '0, 0, 1);
    step(1, rnd_blk(), 0, 1);
    chk("wwp_no_ovf", 128'(io.ovf), 128'(0));
    chk("wwp_occ", 128'(dut.u_fifo.occ), 128'(4));
    repeat (17) step(0, '0, 0, 1);
    chk("wwp_drained", 128'(io.dout_vld), 128'(0));

    // unsolicited block and simultaneous fire/plaintext
    reset_dut();
    step(1, rnd_blk(), 0, 0);
    chk("unsol_set", 128'({io.unsol, io.dout_vld}), 128'(2'b11));
    step(0, '0, 1, 0);
    step(1, rnd_blk(), 1, 0);
    chk("inflight_same", 128'(dut.inflight), 128'(1));

    // random traffic
    reset_dut();
    for (int i = 0; i < 500; i++) begin
      bit cf, pv, rdy;
      cf = ((q.size() + m_infl) < D && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0;
      pv = (m_infl > 0 && $urandom_range(0, 1) == 0) || $urandom_range(0, 39) == 0;
      rdy = $urandom_range(0, 3) != 0;
      step(pv, rnd_blk(), cf, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
